// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register/status encodings and
// the state type for the write-back status machine.
package y86_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int CNT_W_DEF = 32;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [2:0] {
    STAT_BUB = 3'd0,
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

  typedef enum logic {
    WB_RUN    = 1'b0,
    WB_HALTED = 1'b1
  } wb_state_t;

  // Any of these statuses stops the machine for good.
  function automatic logic isStopStat(stat_t s);
    return (s == STAT_HLT) || (s == STAT_ADR) || (s == STAT_INS);
  endfunction

endpackage

// File: rtl/wb_status_fsm.sv
// RUN/HALTED status machine: captures the stopping cause, drives the
// architectural status and counts retired instructions.
module wb_status_fsm
  import y86_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  stat_t            w_stat_i,
  input  logic             fresh_i,
  output logic             run_o,
  output logic             halted_o,
  output stat_t            stat_o,
  output logic [CNT_W-1:0] retired_o
);

  wb_state_t        state_q, state_d;
  stat_t            cause_q, cause_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WB_RUN;
      cause_q   <= STAT_AOK;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  // fresh_i makes a stalled instruction count only on its first cycle in W.
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    retired_d = retired_q;
    if (state_q == WB_RUN) begin
      if (fresh_i && (w_stat_i == STAT_AOK)) begin
        retired_d = retired_q + CNT_W'(1);
      end
      if (isStopStat(w_stat_i)) begin
        state_d = WB_HALTED;
        cause_d = w_stat_i;
      end
    end
  end

  always_comb begin
    run_o     = (state_q == WB_RUN);
    halted_o  = (state_q == WB_HALTED);
    retired_o = retired_q;
    if (state_q == WB_HALTED) begin
      stat_o = cause_q;
    end else if (w_stat_i == STAT_BUB) begin
      stat_o = STAT_AOK;
    end else begin
      stat_o = w_stat_i;
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Y86-64 write-back stage: W pipeline register, register-file write port
// gating and the status/retire machine.
module writeback_stage
  import y86_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       m_icode,
  input  logic [2:0]       m_stat,
  input  logic [3:0]       m_dstE,
  input  logic [3:0]       m_dstM,
  input  logic [WIDTH-1:0] m_valE,
  input  logic [WIDTH-1:0] m_valM,
  input  logic             w_stall,
  input  logic             w_bubble,
  output logic [3:0]       dstE,
  output logic [3:0]       dstM,
  output logic [WIDTH-1:0] valE,
  output logic [WIDTH-1:0] valM,
  output logic [2:0]       stat,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  logic [3:0]       icode_q, icode_d;
  stat_t            stat_q, stat_d;
  logic [3:0]       dstE_q, dstE_d;
  logic [3:0]       dstM_q, dstM_d;
  logic [WIDTH-1:0] valE_q, valE_d;
  logic [WIDTH-1:0] valM_q, valM_d;
  logic             fresh_q, fresh_d;

  logic             run;
  stat_t            archStat;
  logic             writeEn;
  logic             unused_icode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icode_q <= I_NOP;
      stat_q  <= STAT_BUB;
      dstE_q  <= RNONE;
      dstM_q  <= RNONE;
      valE_q  <= '0;
      valM_q  <= '0;
      fresh_q <= 1'b0;
    end else begin
      icode_q <= icode_d;
      stat_q  <= stat_d;
      dstE_q  <= dstE_d;
      dstM_q  <= dstM_d;
      valE_q  <= valE_d;
      valM_q  <= valM_d;
      fresh_q <= fresh_d;
    end
  end

  // Once halted the register is frozen; stall outranks bubble.
  always_comb begin
    icode_d = icode_q;
    stat_d  = stat_q;
    dstE_d  = dstE_q;
    dstM_d  = dstM_q;
    valE_d  = valE_q;
    valM_d  = valM_q;
    fresh_d = fresh_q;
    if (run) begin
      if (w_stall) begin
        fresh_d = 1'b0;
      end else if (w_bubble) begin
        icode_d = I_NOP;
        stat_d  = STAT_BUB;
        dstE_d  = RNONE;
        dstM_d  = RNONE;
        valE_d  = '0;
        valM_d  = '0;
        fresh_d = 1'b0;
      end else begin
        icode_d = m_icode;
        stat_d  = stat_t'(m_stat);
        dstE_d  = m_dstE;
        dstM_d  = m_dstM;
        valE_d  = m_valE;
        valM_d  = m_valM;
        fresh_d = 1'b1;
      end
    end
  end

  // When both ports target the same register (popq %rsp) the M write wins.
  always_comb begin
    writeEn = run && (stat_q == STAT_AOK);
    dstM    = writeEn ? dstM_q : RNONE;
    dstE    = RNONE;
    if (writeEn && !((dstE_q == dstM_q) && (dstM_q != RNONE))) begin
      dstE = dstE_q;
    end
    valE = valE_q;
    valM = valM_q;
  end

  assign unused_icode = ^icode_q;

  wb_status_fsm #(
    .CNT_W(CNT_W)
  ) u_status (
    .clk      (clk),
    .rst_n    (rst_n),
    .w_stat_i (stat_q),
    .fresh_i  (fresh_q),
    .run_o    (run),
    .halted_o (halted),
    .stat_o   (archStat),
    .retired_o(retired)
  );

  assign stat = archStat;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: hand-computed expectations for writes,
// stall/bubble handling, halting and asynchronous reset.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  m_icode;
  logic [2:0]  m_stat;
  logic [3:0]  m_dstE;
  logic [3:0]  m_dstM;
  logic [63:0] m_valE;
  logic [63:0] m_valM;
  logic        w_stall;
  logic        w_bubble;
  logic [3:0]  dstE;
  logic [3:0]  dstM;
  logic [63:0] valE;
  logic [63:0] valM;
  logic [2:0]  stat;
  logic        halted;
  logic [31:0] retired;

  logic [63:0] rf [16];
  int          errCount = 0;
  int          checkCount = 0;

  writeback_stage #(.WIDTH(64), .CNT_W(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m_icode (m_icode),
    .m_stat  (m_stat),
    .m_dstE  (m_dstE),
    .m_dstM  (m_dstM),
    .m_valE  (m_valE),
    .m_valM  (m_valM),
    .w_stall (w_stall),
    .w_bubble(w_bubble),
    .dstE    (dstE),
    .dstM    (dstM),
    .valE    (valE),
    .valM    (valM),
    .stat    (stat),
    .halted  (halted),
    .retired (retired)
  );

  always #5 clk = ~clk;

  // Register-file model fed by the write port; M lands after E so it wins.
  always @(posedge clk) begin
    if (rst_n) begin
      if (dstE != 4'hF) rf[dstE] <= valE;
      if (dstM != 4'hF) rf[dstM] <= valM;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] icode, input logic [2:0] st,
                               input logic [3:0] de, input logic [3:0] dm,
                               input logic [63:0] ve, input logic [63:0] vm,
                               input logic stall, input logic bubble);
    m_icode  = icode;
    m_stat   = st;
    m_dstE   = de;
    m_dstM   = dm;
    m_valE   = ve;
    m_valM   = vm;
    w_stall  = stall;
    w_bubble = bubble;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = '0;
    rst_n = 1'b0;
    applyStimulus(4'h1, 3'd0, 4'hF, 4'hF, 64'd0, 64'd0, 1'b0, 1'b0);
    #3;
    checkOutput("rst_dstE", 64'(dstE), 64'hF);
    checkOutput("rst_dstM", 64'(dstM), 64'hF);
    checkOutput("rst_stat", 64'(stat), 64'd1);
    checkOutput("rst_halted", 64'(halted), 64'd0);
    checkOutput("rst_retired", 64'(retired), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // irmovq $525, %rbx
    applyStimulus(4'h3, 3'd1, 4'h3, 4'hF, 64'd525, 64'd0, 1'b0, 1'b0);
    tick();
    checkOutput("irmov_dstE", 64'(dstE), 64'd3);
    checkOutput("irmov_valE", valE, 64'd525);
    checkOutput("irmov_dstM", 64'(dstM), 64'hF);
    checkOutput("irmov_retired0", 64'(retired), 64'd0);

    // mrmovq into %rax, then stalled for two cycles
    applyStimulus(4'h5, 3'd1, 4'hF, 4'h0, 64'd0, 64'd999, 1'b0, 1'b0);
    tick();
    checkOutput("irmov_rbx", rf[3], 64'd525);
    checkOutput("irmov_retired1", 64'(retired), 64'd1);
    checkOutput("mrmov_dstM", 64'(dstM), 64'd0);
    checkOutput("mrmov_valM", valM, 64'd999);
    checkOutput("mrmov_dstE", 64'(dstE), 64'hF);
    applyStimulus(4'h6, 3'd1, 4'h7, 4'hF, 64'd1, 64'd0, 1'b1, 1'b0);
    tick();
    checkOutput("stall1_dstM", 64'(dstM), 64'd0);
    checkOutput("stall1_valM", valM, 64'd999);
    checkOutput("stall1_retired", 64'(retired), 64'd2);
    tick();
    checkOutput("stall2_dstM", 64'(dstM), 64'd0);
    checkOutput("stall2_dstE", 64'(dstE), 64'hF);
    checkOutput("stall2_retired", 64'(retired), 64'd2);

    // popq %rsp: both ports name rsp
    applyStimulus(4'hB, 3'd1, 4'h4, 4'h4, 64'h108, 64'h200, 1'b0, 1'b0);
    tick();
    checkOutput("popq_dstE", 64'(dstE), 64'hF);
    checkOutput("popq_dstM", 64'(dstM), 64'd4);
    checkOutput("popq_valE", valE, 64'h108);
    checkOutput("popq_retired", 64'(retired), 64'd2);

    // bubble overrides presented AOK data
    applyStimulus(4'h6, 3'd1, 4'h2, 4'hF, 64'd77, 64'd0, 1'b0, 1'b1);
    tick();
    checkOutput("popq_rsp", rf[4], 64'h200);
    checkOutput("popq_retired1", 64'(retired), 64'd3);
    checkOutput("bub_dstE", 64'(dstE), 64'hF);
    checkOutput("bub_dstM", 64'(dstM), 64'hF);
    checkOutput("bub_stat", 64'(stat), 64'd1);

    // halt
    applyStimulus(4'h0, 3'd2, 4'hF, 4'hF, 64'd0, 64'd0, 1'b0, 1'b0);
    tick();
    checkOutput("hlt_retired", 64'(retired), 64'd3);
    checkOutput("hlt_stat", 64'(stat), 64'd2);
    checkOutput("hlt_halted0", 64'(halted), 64'd0);
    checkOutput("hlt_dstE", 64'(dstE), 64'hF);
    applyStimulus(4'h3, 3'd1, 4'h5, 4'hF, 64'd42, 64'd0, 1'b0, 1'b0);
    tick();
    checkOutput("hlt_halted1", 64'(halted), 64'd1);
    checkOutput("hlt_stat1", 64'(stat), 64'd2);
    checkOutput("hlt_dstE1", 64'(dstE), 64'hF);
    tick();
    checkOutput("hlt_dstE2", 64'(dstE), 64'hF);
    checkOutput("hlt_dstM2", 64'(dstM), 64'hF);
    checkOutput("hlt_retired2", 64'(retired), 64'd3);
    checkOutput("hlt_rbp", rf[5], 64'd0);

    // asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_halted", 64'(halted), 64'd0);
    checkOutput("arst_stat", 64'(stat), 64'd1);
    checkOutput("arst_retired", 64'(retired), 64'd0);
    checkOutput("arst_dstE", 64'(dstE), 64'hF);
    checkOutput("arst_dstM", 64'(dstM), 64'hF);
    @(negedge clk);
    rst_n = 1'b1;

    // stall and bubble together: stall wins; then an address fault
    applyStimulus(4'h3, 3'd1, 4'h6, 4'hF, 64'd11, 64'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(4'h6, 3'd1, 4'h2, 4'hF, 64'd5, 64'd0, 1'b1, 1'b1);
    tick();
    checkOutput("sb_dstE", 64'(dstE), 64'd6);
    checkOutput("sb_valE", valE, 64'd11);
    checkOutput("sb_retired", 64'(retired), 64'd1);
    applyStimulus(4'h5, 3'd3, 4'hF, 4'h2, 64'd0, 64'd33, 1'b0, 1'b0);
    tick();
    checkOutput("adr_stat", 64'(stat), 64'd3);
    checkOutput("adr_dstM", 64'(dstM), 64'hF);
    checkOutput("adr_rsi", rf[6], 64'd11);
    tick();
    checkOutput("adr_halted", 64'(halted), 64'd1);
    checkOutput("adr_stat1", 64'(stat), 64'd3);
    checkOutput("adr_retired", 64'(retired), 64'd1);
    checkOutput("adr_rdx", rf[2], 64'd0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Write-side counterpart of the decode stage for the Y86-64 core: decode reads the register file through srcA/srcB; this block owns the register-file write port (dstE/dstM/valE/valM).
- Holds the W pipeline register, which is loaded from memory-stage results with stall/bubble control.
- Gates register writes with processor status and runs a sticky halt FSM.
- Provides a retired-instruction counter and forwarding taps for decode.

Parameters:
- WIDTH, 64, datapath width of valE/valM.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- m_icode  in  4  icode from memory stage.
- m_stat  in  3  status from memory stage (BUB=0, AOK=1, HLT=2, ADR=3, INS=4).
- m_dstE  in  4  E destination; cnd already resolved upstream; 4'hF = RNONE.
- m_dstM  in  4  M destination; 4'hF = RNONE.
- m_valE  in  WIDTH  ALU result.
- m_valM  in  WIDTH  memory read data.
- w_stall  in  1  hold W register.
- w_bubble  in  1  load bubble into W register.
- dstE  out  4  register-file E write address.
- dstM  out  4  register-file M write address.
- valE  out  WIDTH  register-file E write data.
- valM  out  WIDTH  register-file M write data.
- stat  out  3  architectural status.
- halted  out  1  sticky stop indicator.
- retired  out  CNT_W  count of retired AOK instructions.

Behaviour:
- Reset (async, rst_n=0):
  - W register = bubble: icode=1 (nop), stat=BUB, dstE=dstM=F, vals=0, fresh=0.
  - FSM = RUN; halted=0; retired=0; stat=AOK.
- W register load at posedge in RUN:
  - w_stall=1: hold; fresh cleared.
  - else w_bubble=1: load bubble; fresh=0.
  - else: load all m_* inputs; fresh=1.
  - w_stall has priority over w_bubble.
- Write gating (combinational from W register, single-cycle latency from load to write):
  - W_stat==AOK and FSM==RUN: dstE=W_dstE, dstM=W_dstM, valE/valM = W values.
  - Otherwise (bubble, HLT, ADR, INS, HALTED): dstE=dstM=F; valE/valM still driven from W.
  - W_dstE==W_dstM and both != F (popq %rsp style): dstE forced to F so the M write wins.
- FSM states:
  - RUN -> HALTED when W holds stat in {HLT, ADR, INS}, evaluated at posedge.
  - HALTED is sticky until reset. In HALTED, the W register is frozen (stall/bubble/m_* ignored), writes are suppressed, and retired does not change.
- Outputs:
  - stat = AOK when W_stat==BUB; else W_stat.
  - In HALTED, stat holds the cause captured at the transition.
  - halted = (FSM==HALTED), registered.
- Counter: retired increments by 1 at posedge when FSM==RUN, fresh==1 and W_stat==AOK. A stalled instruction is counted once. Wraps modulo 2^CNT_W.
- Faulting/halting instructions (HLT/ADR/INS) never write registers and are not counted.
- Reset mid-operation: immediate return to the reset values above regardless of FSM state; any in-flight write is dropped.

Decomposition:
- Shared package y86_pkg:
  - icode constants (NOP, HALT, RRMOVQ..POPQ).
  - RNONE=4'hF.
  - stat_t encoding BUB/AOK/HLT/ADR/INS.
  - WIDTH default.
- One natural sub-module: wb_status_fsm (RUN/HALTED, halted/stat capture, retire counter). The W register and write gating stay in the top.

Test Plan:
- irmovq: m_icode=3, m_stat=AOK, m_dstE=3, m_valE=525, no stall -> next cycle dstE=3, valE=525, dstM=F; registerfile rbx=525 after following edge; retired=1.
- mrmovq with stall: m_icode=5, m_dstM=0, m_valM=999; then w_stall=1 for 2 cycles -> dstM=0, valM=999 held for 3 cycles; retired increments only once.
- popq %rsp: m_dstE=4, m_dstM=4, valE=0x108, valM=0x200 -> dstE=F, dstM=4; rsp=0x200.
- bubble: w_bubble=1 while AOK data is presented -> dstE=dstM=F, stat=AOK, retired unchanged.
- halt: m_stat=HLT loaded -> no writes; next edge halted=1, stat=HLT. Later AOK inputs with stall=bubble=0 -> still dstE=dstM=F and retired frozen.
- async reset asserted mid-HALTED, between clock edges -> halted=0, stat=AOK, retired=0, dstE=dstM=F immediately.
